byte_load_unit: RTL and testbench
=================================

Name: byte_load_unit

Overview:
- Sequential load/extract unit for the basic CPU: the read-side counterpart of the byte-write path.
- Fetches a word from data memory over a request/acknowledge handshake.
- Selects a byte by address LSB (little-endian) and zero- or sign-extends it to 16 bits.
- Also performs register-only SXT/ZXT, and returns the result to the register file with a one-cycle done pulse.

Parameters:
- TIMEOUT, 16, max cycles mem_rd stays asserted without mem_ack before the access aborts with err.
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- E  input  1  clock; all state updates on posedge E
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  3  0=LDW word, 1=LDBZ byte zero-ext, 2=LDBS byte sign-ext, 3=SXT src_in[7:0], 4=ZXT src_in[7:0], 5-7 illegal
- addr  input  16  byte address for ops 0-2
- src_in  input  16  register operand for ops 3-4
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse; result and err valid while high
- err  output  1  error flag, qualified by done
- result  output  16  extracted/extended value; holds until next completion
- mem_addr  output  16  word address = {addr[15:1],1'b0}
- mem_rd  output  1  read request, held until ack or timeout
- mem_rdata  input  16  memory read data, valid when mem_ack=1
- mem_ack  input  1  memory acknowledge, single-cycle

Behaviour:
- Reset (rst=1 at posedge E): state=IDLE; busy=0, done=0, err=0, result=16'h0000, mem_rd=0, mem_addr=16'h0000, timeout counter=0. Reset has priority over everything, including mid-access; any in-flight ack is discarded.
- States: IDLE, WAIT, DONE. All outputs are registered.
- IDLE:
  - start=1 and op in {0,1,2} with a legal address: latch op and addr[0]; drive mem_addr; mem_rd=1; counter=0; go to WAIT.
  - start=1 and op=0 with addr[0]=1 (misaligned word): no memory access; err=1, result=0; go to DONE.
  - start=1 and op in {3,4}: compute result from src_in; err=0; go to DONE. No memory access.
  - start=1 and op in {5,6,7}: err=1, result=0; go to DONE.
- WAIT:
  - mem_ack=1: mem_rd=0. result = LDW: mem_rdata; LDBZ: {8'h00, byte}; LDBS: {{8{byte[7]}}, byte}, where byte = addr[0] ? mem_rdata[15:8] : mem_rdata[7:0]. err=0; go to DONE.
  - mem_ack=0: counter+1. When counter reaches TIMEOUT-1 and ack is still low: mem_rd=0, err=1, result=0, go to DONE. An ack on that same final cycle wins: normal completion.
- DONE: done=1 for exactly one cycle; next state is IDLE. start in DONE is ignored.
- start while busy is ignored; there is no queueing.
- mem_ack outside WAIT is ignored.
- SXT: {{8{src_in[7]}}, src_in[7:0]}. ZXT: {8'h00, src_in[7:0]}.
- Latency, counting start sampled at edge N:
  - Register-only ops and error cases: done high after edge N+1.
  - Memory ops: mem_rd high after edge N; ack sampled at edge M gives done high after edge M+1.
- result and err keep their last values in IDLE. err is cleared on the next successful completion.

Test Plan:
- Reset: hold rst 2 cycles mid-WAIT with mem_rd=1 -> all outputs 0, state IDLE, a late mem_ack is ignored, and the next start works normally.
- LDBS at addr=16'h1001 with mem_rdata=16'h8A34, ack 3 cycles after mem_rd -> mem_addr=16'h1000, mem_rd high exactly 3 cycles, done pulse with result=16'hFF8A, err=0.
- LDBZ at addr=16'h2000 with mem_rdata=16'h8AF4 -> result=16'h00F4; LDW at 16'h2000 -> result=16'h8AF4.
- LDW at addr=16'h3003 -> mem_rd never asserts; done one cycle later with err=1, result=0.
- SXT src_in=16'h1280 -> result=16'hFF80. ZXT src_in=16'hFF7F -> result=16'h007F. Each done arrives 1 cycle after start; op=6 gives err=1.
- Timeout: no ack with TIMEOUT=16 -> mem_rd drops after 16 cycles, done with err=1. Repeat with ack on the 16th cycle -> normal result, err=0. A start pulsed during WAIT is ignored.

Source files
------------

// File: rtl/byte_load_unit.sv
// byte_load_unit: read-side load/extract unit for the basic CPU.
// Fetches a 16-bit word over a request/acknowledge handshake, selects a byte by
// address LSB (little-endian) and zero- or sign-extends it, or performs the
// register-only SXT/ZXT. The result is returned with a one-cycle done pulse.
//
// Ports:
//   E          clock (all state updates on posedge)
//   rst        synchronous active-high reset
//   start      request, sampled only when idle
//   op         0=LDW 1=LDBZ 2=LDBS 3=SXT 4=ZXT 5-7 illegal
//   addr       byte address for memory ops
//   src_in     register operand for SXT/ZXT
//   busy       high whenever the unit is not idle
//   done       one-cycle completion pulse; result/err valid while high
//   err        error flag qualified by done
//   result     extracted/extended value, held until the next completion
//   mem_addr   word-aligned memory address
//   mem_rd     memory read request, held until ack or timeout
//   mem_rdata  memory read data, valid with mem_ack
//   mem_ack    single-cycle memory acknowledge
module byte_load_unit #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        E,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [15:0] addr,
  input  logic [15:0] src_in,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] result,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [2:0] OP_LDW  = 3'd0;
  localparam logic [2:0] OP_LDBZ = 3'd1;
  localparam logic [2:0] OP_LDBS = 3'd2;
  localparam logic [2:0] OP_SXT  = 3'd3;
  localparam logic [2:0] OP_ZXT  = 3'd4;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic               lsb_q, lsb_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [15:0]        result_q, result_d;
  logic [15:0]        mem_addr_q, mem_addr_d;
  logic               mem_rd_q, mem_rd_d;
  logic [7:0]         rd_byte;

  // Only the low byte of src_in participates in SXT/ZXT.
  logic unused_src_hi;
  assign unused_src_hi = ^src_in[15:8];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    lsb_d      = lsb_q;
    done_d     = 1'b0;
    err_d      = err_q;
    result_d   = result_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = mem_rd_q;
    rd_byte    = lsb_q ? mem_rdata[15:8] : mem_rdata[7:0];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_LDW, OP_LDBZ, OP_LDBS: begin
              if (op == OP_LDW && addr[0]) begin
                // Misaligned word load: reported without touching memory.
                err_d    = 1'b1;
                result_d = '0;
                state_d  = S_DONE;
              end else begin
                op_d       = op;
                lsb_d      = addr[0];
                mem_addr_d = {addr[15:1], 1'b0};
                mem_rd_d   = 1'b1;
                cnt_d      = '0;
                state_d    = S_WAIT;
              end
            end
            OP_SXT: begin
              result_d = {{8{src_in[7]}}, src_in[7:0]};
              err_d    = 1'b0;
              state_d  = S_DONE;
            end
            OP_ZXT: begin
              result_d = {8'h00, src_in[7:0]};
              err_d    = 1'b0;
              state_d  = S_DONE;
            end
            default: begin
              err_d    = 1'b1;
              result_d = '0;
              state_d  = S_DONE;
            end
          endcase
        end
      end

      S_WAIT: begin
        // Ack is tested before the timeout so an ack on the final cycle wins.
        if (mem_ack) begin
          mem_rd_d = 1'b0;
          err_d    = 1'b0;
          case (op_q)
            OP_LDBZ: result_d = {8'h00, rd_byte};
            OP_LDBS: result_d = {{8{rd_byte[7]}}, rd_byte};
            default: result_d = mem_rdata;
          endcase
          state_d = S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          mem_rd_d = 1'b0;
          err_d    = 1'b1;
          result_d = '0;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        // done is registered, so the pulse appears in the cycle after DONE.
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge E) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      lsb_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      result_q   <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      lsb_q      <= lsb_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      result_q   <= result_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign result   = result_q;
  assign mem_addr = mem_addr_q;
  assign mem_rd   = mem_rd_q;

endmodule

// File: tb/tb_byte_load_unit.sv
// Self-checking bench for byte_load_unit: directed vector table, hand-written
// multi-cycle sequences (reset mid-access, start while busy/done) and random
// transactions checked against a behavioural model.
module tb_byte_load_unit;

  localparam int TO = 16;

  logic        E;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [15:0] addr;
  logic [15:0] src_in;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] result;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  int n_vec = 0;
  int n_bad = 0;

  byte_load_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
    .E         (E),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .addr      (addr),
    .src_in    (src_in),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .result    (result),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  initial E = 1'b0;
  always #5 E = ~E;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] addr;
    logic [15:0] src;
    logic [15:0] rdata;
    int          d;        // cycles mem_rd is high before ack; 0 = never ack
    logic [15:0] exp_res;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];

  task automatic step();
    @(posedge E);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference behaviour from the architectural rules.
  function automatic void model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] s,
                                input logic [15:0] rd, input int d,
                                output logic [15:0] res, output logic er,
                                output int nrd, output int lat);
    int b;
    int lo;
    bit is_mem;
    res = 16'h0000; er = 1'b0; nrd = 0; lat = 1;
    is_mem = (o == 3'd0 && a[0] == 1'b0) || o == 3'd1 || o == 3'd2;
    lo = int'(s) % 256;
    if (is_mem) begin
      if (d >= 1 && d <= TO) begin
        nrd = d;
        b = a[0] ? int'(rd) / 256 : int'(rd) % 256;
        if (o == 3'd0)      res = rd;
        else if (o == 3'd1) res = 16'(b);
        else                res = 16'((b >= 128) ? b + 'hFF00 : b);
      end else begin
        nrd = TO;
        er  = 1'b1;
      end
      lat = nrd + 1;
    end else if (o == 3'd3) begin
      res = 16'((lo >= 128) ? lo + 'hFF00 : lo);
    end else if (o == 3'd4) begin
      res = 16'(lo);
    end else begin
      er = 1'b1;
    end
  endfunction

  task automatic run_txn(input string nm, input logic [2:0] o, input logic [15:0] a,
                         input logic [15:0] s, input logic [15:0] rd, input int d,
                         input logic [15:0] exp_res, input logic exp_err);
    logic [15:0] m_res;
    logic        m_err;
    int          exp_nrd;
    int          exp_lat;
    int          nrd;
    int          lat;
    bit          got_done;
    logic [15:0] seen_addr;
    model(o, a, s, rd, d, m_res, m_err, exp_nrd, exp_lat);
    start = 1'b1; op = o; addr = a; src_in = s;
    step();
    start = 1'b0; op = 3'($urandom); addr = 16'($urandom); src_in = 16'($urandom);
    check({nm, "_busy"}, busy, 1'b1);
    nrd = 0; lat = 0; got_done = 1'b0; seen_addr = 16'h0000;
    for (int c = 0; c < 64; c++) begin
      if (done) begin
        got_done = 1'b1;
        lat = c;
        break;
      end
      if (mem_rd) begin
        if (nrd == 0) seen_addr = mem_addr;
        nrd++;
      end
      mem_ack   = (d >= 1 && mem_rd && nrd == d);
      mem_rdata = mem_ack ? rd : 16'($urandom);
      step();
      mem_ack = 1'b0;
    end
    check({nm, "_done_seen"}, got_done, 1'b1);
    check({nm, "_latency"}, lat, exp_lat);
    check({nm, "_mem_rd_cycles"}, nrd, exp_nrd);
    if (exp_nrd > 0) check({nm, "_mem_addr"}, seen_addr, {a[15:1], 1'b0});
    check({nm, "_result"}, result, exp_res);
    check({nm, "_err"}, err, exp_err);
    step();
    check({nm, "_done_drop"}, done, 1'b0);
    check({nm, "_idle"}, busy, 1'b0);
    check({nm, "_hold"}, result, exp_res);
  endtask

  initial begin
    vec_t v;
    logic [15:0] r_res;
    logic        r_err;
    int          r_nrd;
    int          r_lat;
    logic [2:0]  ro;
    logic [15:0] ra;
    logic [15:0] rs;
    logic [15:0] rr;
    int          rd_cyc;

    vecs[0]  = '{3'd2, 16'h1001, 16'h0000, 16'h8A34,  3, 16'hFF8A, 1'b0};
    vecs[1]  = '{3'd1, 16'h2000, 16'h0000, 16'h8AF4,  1, 16'h00F4, 1'b0};
    vecs[2]  = '{3'd0, 16'h2000, 16'h0000, 16'h8AF4,  2, 16'h8AF4, 1'b0};
    vecs[3]  = '{3'd0, 16'h3003, 16'h0000, 16'h1111,  1, 16'h0000, 1'b1};
    vecs[4]  = '{3'd3, 16'h0000, 16'h1280, 16'h0000,  0, 16'hFF80, 1'b0};
    vecs[5]  = '{3'd4, 16'h0000, 16'hFF7F, 16'h0000,  0, 16'h007F, 1'b0};
    vecs[6]  = '{3'd6, 16'h0000, 16'h1234, 16'h0000,  0, 16'h0000, 1'b1};
    vecs[7]  = '{3'd1, 16'h0001, 16'h0000, 16'h7F80,  1, 16'h007F, 1'b0};
    vecs[8]  = '{3'd2, 16'h0000, 16'h0000, 16'h1280,  2, 16'hFF80, 1'b0};
    vecs[9]  = '{3'd5, 16'h2000, 16'h0000, 16'h0000,  0, 16'h0000, 1'b1};
    vecs[10] = '{3'd0, 16'h4000, 16'h0000, 16'hBEEF,  0, 16'h0000, 1'b1};
    vecs[11] = '{3'd0, 16'h4000, 16'h0000, 16'hBEEF, 16, 16'hBEEF, 1'b0};
    vecs[12] = '{3'd7, 16'h0000, 16'h0000, 16'h0000,  0, 16'h0000, 1'b1};
    vecs[13] = '{3'd2, 16'h7FFF, 16'h0000, 16'h7F01, 15, 16'h007F, 1'b0};

    rst = 1'b1; start = 1'b0; op = '0; addr = '0; src_in = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    step();
    step();
    check("rst_busy",     busy,     1'b0);
    check("rst_done",     done,     1'b0);
    check("rst_err",      err,      1'b0);
    check("rst_result",   result,   16'h0000);
    check("rst_mem_rd",   mem_rd,   1'b0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      v = vecs[i];
      run_txn($sformatf("vec%0d", i), v.op, v.addr, v.src, v.rdata, v.d, v.exp_res, v.exp_err);
    end

    // start while WAITing and while in DONE must both be ignored.
    start = 1'b1; op = 3'd0; addr = 16'h5000; src_in = 16'h0080;
    step();
    start = 1'b0;
    step();
    start = 1'b1; op = 3'd3;
    step();
    start = 1'b0;
    check("busy_start_mem_rd", mem_rd, 1'b1);
    mem_rdata = 16'hC3A5; mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    start = 1'b1; op = 3'd4; src_in = 16'h00AA;
    step();
    start = 1'b0;
    check("busy_start_done",   done,   1'b1);
    check("busy_start_result", result, 16'hC3A5);
    check("busy_start_err",    err,    1'b0);
    step();
    check("done_start_ignored", done, 1'b0);
    check("done_start_idle",    busy, 1'b0);

    // Reset mid-access: late ack must be discarded.
    start = 1'b1; op = 3'd1; addr = 16'h6001;
    step();
    start = 1'b0;
    step();
    step();
    check("rstw_mem_rd_before", mem_rd, 1'b1);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rstw_busy",     busy,     1'b0);
    check("rstw_done",     done,     1'b0);
    check("rstw_err",      err,      1'b0);
    check("rstw_result",   result,   16'h0000);
    check("rstw_mem_rd",   mem_rd,   1'b0);
    check("rstw_mem_addr", mem_addr, 16'h0000);
    mem_rdata = 16'h55AA; mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("late_ack_done", done, 1'b0);
    check("late_ack_busy", busy, 1'b0);
    step();
    check("late_ack_done2",  done,   1'b0);
    check("late_ack_result", result, 16'h0000);
    run_txn("after_rst", 3'd2, 16'h6001, 16'h0000, 16'h9C00, 2, 16'hFF9C, 1'b0);

    // Random transactions against the reference model.
    for (int k = 0; k < 40; k++) begin
      ro     = 3'($urandom_range(0, 7));
      ra     = 16'($urandom);
      rs     = 16'($urandom);
      rr     = 16'($urandom);
      rd_cyc = $urandom_range(0, TO + 2);
      model(ro, ra, rs, rr, rd_cyc, r_res, r_err, r_nrd, r_lat);
      run_txn($sformatf("rnd%0d", k), ro, ra, rs, rr, rd_cyc, r_res, r_err);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
